// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable multi-slot serial pattern detector
// with per-slot overlap mode and a saturating match counter
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int NUM_PAT = 2,
    parameter int CNT_W = 8,
    localparam int LEN_W = $clog2(MAX_LEN + 1),
    localparam int SEL_W = NUM_PAT > 1 ? $clog2(NUM_PAT) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_we,
    input  logic [SEL_W-1:0]   cfg_sel,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in,
    input  logic               clr_cnt,
    output logic [NUM_PAT-1:0] match,
    output logic               match_any,
    output logic [CNT_W-1:0]   match_cnt
);
    logic               acc;
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-1:0] w;
    logic [LEN_W-1:0]   len_in;

    assign acc = in_valid && !cfg_we;
    assign w = {hist, in};
    assign len_in = cfg_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;
    assign match_any = |match;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) hist <= '0;
        else if (acc) hist <= w[MAX_LEN-2:0];

    for (genvar k = 0; k < NUM_PAT; k++) begin : g_slot
        logic [MAX_LEN-1:0] pat, mask;
        logic [LEN_W-1:0]   len, fill;
        logic               ovl, we;
        assign we = cfg_we && cfg_sel == SEL_W'(k);
        // a full-length shift wraps to zero, so the subtraction yields all ones
        assign mask = (MAX_LEN'(1) << len) - MAX_LEN'(1);
        assign match[k] = acc && len != '0 && fill >= len - LEN_W'(1) && ((w ^ pat) & mask) == '0;
        always_ff @(posedge clk or negedge rstn)
            if (!rstn) begin
                pat  <= '0;
                len  <= '0;
                ovl  <= 1'b1;
                fill <= '0;
            end else if (we) begin
                pat  <= cfg_pattern;
                len  <= len_in;
                ovl  <= cfg_overlap;
                fill <= '0;
            end else if (acc) begin
                fill <= (match[k] && !ovl) ? '0 : fill == LEN_W'(MAX_LEN) ? fill : fill + LEN_W'(1);
            end
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) match_cnt <= '0;
        else if (clr_cnt) match_cnt <= '0;
        else if (match_any && !(&match_cnt)) match_cnt <= match_cnt + CNT_W'(1);
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench with a bit-history reference model,
// driving a default instance and a 2-bit-counter instance in lockstep
module tb_seq_detector_param;
    localparam int ML = 8;
    localparam int NP = 2;

    logic       clk = 0, rstn = 0, cfg_we = 0, cfg_overlap = 0, in_valid = 0, in = 0, clr_cnt = 0;
    logic [0:0] cfg_sel = '0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic [1:0] match, match2;
    logic       match_any, any2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int checks = 0, errors = 0;

    typedef struct packed {
        logic [1:0] m;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;
    exp_t sb[$];
    exp_t me;

    int         mlen[NP];
    logic [7:0] mpat[NP];
    bit         movl[NP];
    int         mfill[NP];
    bit         gh[$];
    int         c8, c2;

    seq_detector_param dut (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in),
        .clr_cnt(clr_cnt), .match(match), .match_any(match_any), .match_cnt(cnt)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in),
        .clr_cnt(clr_cnt), .match(match2), .match_any(any2), .match_cnt(cnt2)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NP; k++) begin
            mlen[k] = 0;
            mpat[k] = '0;
            movl[k] = 1'b1;
            mfill[k] = 0;
        end
        gh.delete();
        c8 = 0;
        c2 = 0;
    endfunction

    // last mlen[k] stream bits (newest = b) read oldest-first must spell the pattern MSB-first
    function automatic bit tail_ok(int k, bit b);
        for (int i = 0; i < mlen[k]; i++) begin
            bit wi;
            wi = (i == 0) ? b : (gh.size() >= i ? gh[gh.size() - i] : 1'b0);
            if (wi != mpat[k][i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(bit we, int sel, logic [7:0] p, int l, bit o, bit v, bit b, bit clr);
        exp_t e;
        bit   acc;
        @(posedge clk);
        #1;
        cfg_we = we;
        cfg_sel = sel[0];
        cfg_pattern = p;
        cfg_len = l[3:0];
        cfg_overlap = o;
        in_valid = v;
        in = b;
        clr_cnt = clr;
        acc = v && !we;
        e.m = '0;
        if (acc)
            for (int k = 0; k < NP; k++)
                if (mlen[k] > 0 && mfill[k] + 1 >= mlen[k] && tail_ok(k, b)) e.m[k] = 1'b1;
        e.c8 = c8[7:0];
        e.c2 = c2[1:0];
        if (v || we) sb.push_back(e);
        if (clr) begin
            c8 = 0;
            c2 = 0;
        end else if (e.m != 0) begin
            if (c8 < 255) c8++;
            if (c2 < 3) c2++;
        end
        if (we && sel < NP) begin
            mpat[sel] = p;
            mlen[sel] = l > ML ? ML : l;
            movl[sel] = o;
            mfill[sel] = 0;
        end
        if (acc) begin
            for (int k = 0; k < NP; k++)
                mfill[k] = (e.m[k] && !movl[k]) ? 0 : (mfill[k] < ML ? mfill[k] + 1 : ML);
            gh.push_back(b);
            if (gh.size() > ML) void'(gh.pop_front());
        end
    endtask

    task automatic send(bit b, bit clr = 0);
        step(0, 0, '0, 0, 0, 1, b, clr);
    endtask

    task automatic cfg(int sel, logic [7:0] p, int l, bit o, bit v = 0, bit b = 0);
        step(1, sel, p, l, o, v, b, 0);
    endtask

    task automatic idle(int n, bit clr = 0);
        repeat (n) step(0, 0, '0, 0, 0, 0, 0, clr);
    endtask

    task automatic send_bits(logic [15:0] bits, int n, int maxgap);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i]);
            if (maxgap > 0) idle($urandom_range(maxgap, 0));
        end
    endtask

    always @(negedge clk) begin
        if (rstn && (in_valid || cfg_we)) begin
            if (sb.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
            else begin
                me = sb.pop_front();
                chk("match", 32'(match), 32'(me.m));
                chk("match_any", 32'(match_any), 32'(|me.m));
                chk("match_w2", 32'(match2), 32'(me.m));
                chk("cnt", 32'(cnt), 32'(me.c8));
                chk("cnt_w2", 32'(cnt2), 32'(me.c2));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #2;
        chk("rst_match", 32'(match), 32'(0));
        chk("rst_any", 32'(match_any), 32'(0));
        chk("rst_cnt", 32'(cnt), 32'(0));
        @(posedge clk);
        #1 rstn = 1;
        send_bits(16'b1001, 4, 0);

        cfg(0, 8'b1001, 4, 1);
        cfg(1, 8'b010, 3, 1);
        send_bits(16'b10010010, 8, 0);
        idle(1);
        chk("cnt_stream1", 32'(cnt), 32'(4));
        chk("cnt_w2_sat", 32'(cnt2), 32'(3));

        idle(1, 1);
        cfg(0, 8'b1001, 4, 0);
        cfg(1, 8'b0, 0, 1);
        send_bits(16'b10010010, 8, 0);
        idle(1);
        chk("cnt_nonovl", 32'(cnt), 32'(1));

        cfg(0, 8'b1001, 4, 1);
        send_bits(16'b100, 3, 0);
        cfg(0, 8'b1001, 4, 1, 1, 1);
        send_bits(16'b1001, 4, 0);

        cfg(1, 8'b010, 3, 1);
        send_bits(16'b10010010, 8, 3);

        send_bits(16'b100, 3, 0);
        send(1, 1);
        idle(1);
        chk("clr_wins", 32'(cnt), 32'(0));

        cfg(0, 8'b1001, 4, 1);
        send(1);
        send(0);
        @(posedge clk);
        #1;
        rstn = 0;
        cfg_we = 0;
        in_valid = 1;
        in = 1;
        #1;
        chk("rst_mid_match", 32'(match), 32'(0));
        chk("rst_mid_any", 32'(match_any), 32'(0));
        chk("rst_mid_cnt", 32'(cnt), 32'(0));
        chk("rst_mid_cnt_w2", 32'(cnt2), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        in_valid = 0;
        rstn = 1;
        send_bits(16'b1001, 4, 0);
        cfg(0, 8'b1001, 4, 1);
        send_bits(16'b01, 2, 0);
        send_bits(16'b1001, 4, 0);
        idle(1);
        chk("rst_reprog_cnt", 32'(cnt), 32'(1));

        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(99, 0);
            if (r < 4) cfg($urandom_range(1, 0), 8'($urandom), $urandom_range(9, 0), 1'($urandom), 1'($urandom), 1'($urandom));
            else if (r < 8) cfg($urandom_range(1, 0), 8'($urandom), $urandom_range(3, 1), 1'($urandom));
            else if (r < 25) idle(1, r < 11);
            else send(1'($urandom), r > 97);
        end

        idle(2);
        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector for up to `NUM_PAT` runtime-programmable bit patterns, each up to `MAX_LEN` bits long. It accepts one qualified input bit per clock and flags each slot whose pattern ends on that bit. Each slot can run in overlapping or non-overlapping mode, and a saturating counter records the match activity. It is the generalised replacement for the fixed-pattern (1001/010) detectors and sits directly on a serial bit stream.

## Interface
Parameters:
- `MAX_LEN`, default 8: maximum pattern length in bits (≥2).
- `NUM_PAT`, default 2: number of independent pattern slots (≥1).
- `CNT_W`, default 8: width of the match counter.
- Derived: `LEN_W = $clog2(MAX_LEN+1)`, `SEL_W = max(1, $clog2(NUM_PAT))`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rstn`, in, 1: asynchronous active-low reset.
- `cfg_we`, in, 1: write the slot selected by `cfg_sel`.
- `cfg_sel`, in, `SEL_W`: slot index. A value ≥ `NUM_PAT` makes the write a no-op.
- `cfg_pattern`, in, `MAX_LEN`: pattern bits. Bit `[len-1]` is the first bit received and bit `[0]` is the last.
- `cfg_len`, in, `LEN_W`: pattern length. 0 disables the slot; values > `MAX_LEN` are stored as `MAX_LEN`.
- `cfg_overlap`, in, 1: 1 = overlapping detection, 0 = non-overlapping.
- `in_valid`, in, 1: `in` carries a stream bit this cycle.
- `in`, in, 1: serial data bit.
- `clr_cnt`, in, 1: synchronous clear of `match_cnt`.
- `match`, out, `NUM_PAT`: per-slot match flag (Mealy, combinational).
- `match_any`, out, 1: OR of `match`.
- `match_cnt`, out, `CNT_W`: saturating count of cycles where `match_any` = 1.

## Operation
- Shared history register `hist[MAX_LEN-2:0]`; `hist[0]` holds the newest accepted bit.
  - When a bit is accepted, the history shifts: `hist <= {hist[MAX_LEN-3:0], in}`.
  - A bit is accepted when `in_valid` = 1 and `cfg_we` = 0.
- Comparison window: `w[0] = in` and `w[i] = hist[i-1]` for 1 ≤ i < `MAX_LEN`.
- Per-slot registers: `pat_k`, `len_k`, `ovl_k`, and a fill counter `fill_k` (0..`MAX_LEN`, saturating).
  - `fill_k` counts the bits accepted since the slot's last config write, last non-overlap match, or reset.
- Slot k matches (`match[k]` = 1) when all of these hold:
  - a bit is accepted this cycle;
  - `len_k` ≠ 0;
  - `fill_k` ≥ `len_k`-1;
  - `w[i] == pat_k[i]` for every i < `len_k`.
- `fill_k` update when a bit is accepted:
  - If `match[k]` = 1 and `ovl_k` = 0: `fill_k` <= 0.
  - Otherwise: `fill_k` <= min(`fill_k`+1, `MAX_LEN`).
- Config write (`cfg_we` = 1, valid `cfg_sel`): loads `pat`/`len`/`ovl` of that slot and sets its `fill` to 0.
  - Other slots and `hist` are unaffected, except that no bit is accepted this cycle.
  - `cfg_we` has priority over `in_valid`: the bit is dropped and `match` is all zero.
- `match_cnt` update:
  - `clr_cnt` = 1: `match_cnt` <= 0. Clear wins over a simultaneous match.
  - Otherwise, if `match_any` = 1 and `match_cnt` is not all ones: `match_cnt` <= `match_cnt`+1.
  - Otherwise the counter holds; at all ones it stays saturated.
- Idle cycles (`in_valid` = 0) hold all state; gaps are transparent to detection.

## Timing
- Reset (asynchronous, active-low) sets:
  - `hist` = 0;
  - all `pat` = 0, `len` = 0 (all slots disabled), `ovl` = 1;
  - all `fill` = 0, `match_cnt` = 0.
  - `match` and `match_any` are therefore 0 from reset.
- Latency: `match` asserts combinationally in the same cycle as the final pattern bit. `match_cnt` reflects that match after the next rising edge.
- A config write takes effect on the following cycle. The first possible match for the written slot is the `len`-th accepted bit after the write.
- Reset asserted mid-stream discards all partial progress and configuration immediately. After release, nothing matches until the slots are reprogrammed.
- `len` = 1 matches on every accepted bit equal to `pat[0]`, regardless of `fill`.

## Test plan
- Setup: slot0 = 1001 (`len` 4, overlap), slot1 = 010 (`len` 3, overlap). Stream 1,0,0,1,0,0,1,0, one bit per cycle. Required:
  - `match[0]` on bits 4 and 7;
  - `match[1]` on bits 5 and 8;
  - `match_cnt` = 4 after the stream.
- Slot0 = 1001 with `ovl` = 0, same stream: `match[0]` only on bit 4; bit 7 gives no match because `fill` was reset.
- `cfg_we` together with `in_valid`: the bit is dropped and `match` = 0 that cycle. Replaying the preceding bits plus the dropped bit yields the match only after a full `len` bits following the write.
- `in_valid` gaps of 0–3 cycles inserted into the first stream: match positions are unchanged relative to the accepted bits.
- `CNT_W` = 2 with 5 matches: `match_cnt` saturates at 3. `clr_cnt` in the same cycle as a match gives 0.
- Assert `rstn` low after 2 bits of 1001: outputs 0 immediately. After release and reprogramming, the next bits 0,1 alone do not match; a full 1,0,0,1 matches on the 4th bit.
